// File: rtl/square_wave_meter.sv
// Measures the high and low interval lengths of an asynchronous square wave in
// ticks of TICK_DIV clocks, reporting each completed high-then-low period.
module square_wave_meter #(
  parameter int unsigned TICK_DIV = 10,
  parameter int unsigned CW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in,
  output logic [CW-1:0] on_ticks,
  output logic [CW-1:0] off_ticks,
  output logic          valid,
  output logic          overflow,
  output logic          timeout
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TICK_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  state_t        state;
  logic          sync1, in_s, in_d;
  logic [2:0]    fill;
  logic          rise, fall, edge_seen;
  logic [PW-1:0] pre, pre_nx;
  logic [CW-1:0] tick, tick_nx;
  logic [CW-1:0] hi_cap;
  logic          hi_ovf, have_hi;

  // Input synchronizer and edge-detect delay; runs regardless of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      in_s  <= 1'b0;
      in_d  <= 1'b0;
      fill  <= '0;
    end else begin
      sync1 <= in;
      in_s  <= sync1;
      in_d  <= in_s;
      fill  <= {fill[1:0], 1'b1};
    end
  end

  // Chain contents straight after reset are not real samples of in; edges
  // are only trusted once in_d holds a genuine sample.
  assign rise      = fill[2] & in_s & ~in_d;
  assign fall      = fill[2] & ~in_s & in_d;
  assign edge_seen = rise | fall;

  always_comb begin
    pre_nx  = pre + PW'(1);
    tick_nx = tick;
    if (pre == PRE_LAST) begin
      pre_nx  = '0;
      tick_nx = (tick == TICK_MAX) ? tick : tick + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pre       <= '0;
      tick      <= '0;
      hi_cap    <= '0;
      hi_ovf    <= 1'b0;
      have_hi   <= 1'b0;
      on_ticks  <= '0;
      off_ticks <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        have_hi <= 1'b0;
        pre     <= '0;
        tick    <= '0;
        timeout <= 1'b0;
      end else begin
        // The edge cycle itself is clock 1 of the new level.
        if (edge_seen) begin
          pre     <= PW'(1);
          tick    <= '0;
          timeout <= 1'b0;
        end else if (state == IDLE) begin
          pre     <= '0;
          tick    <= '0;
          timeout <= 1'b0;
        end else begin
          pre     <= pre_nx;
          tick    <= tick_nx;
          timeout <= (tick_nx == TICK_MAX);
        end

        case (state)
          IDLE: begin
            if (rise)      state <= MEAS_HIGH;
            else if (fall) state <= MEAS_LOW;
          end
          MEAS_HIGH: begin
            if (fall) begin
              hi_cap  <= tick;
              hi_ovf  <= (tick == TICK_MAX);
              have_hi <= 1'b1;
              state   <= MEAS_LOW;
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              if (have_hi) begin
                on_ticks  <= hi_cap;
                off_ticks <= tick;
                overflow  <= hi_ovf | (tick == TICK_MAX);
                valid     <= 1'b1;
              end
              state <= MEAS_HIGH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_square_wave_meter.sv
// Randomized and directed bench for square_wave_meter; expectations come from
// the driven level lengths via a period-level scoreboard.
module tb_square_wave_meter;

  localparam int TD   = 10;
  localparam int CWB  = 8;
  localparam int MAXT = (1 << CWB) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           in;
  logic [CWB-1:0] on_ticks, off_ticks;
  logic           valid, overflow, timeout;

  square_wave_meter #(.TICK_DIV(TD), .CW(CWB)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in        (in),
    .on_ticks  (on_ticks),
    .off_ticks (off_ticks),
    .valid     (valid),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int on;
    int off;
    int ovf;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: level lengths as driven, in clocks.
  int m_len     = 0;
  int m_hi      = 0;
  bit m_seen    = 0;
  bit m_have_hi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic int to_ticks(input int len);
    return (len / TD > MAXT) ? MAXT : len / TD;
  endfunction

  task automatic model_edge(input logic v);
    exp_t e;
    if (v == 1'b0) begin
      m_have_hi = m_seen;
      m_hi      = m_len;
    end else if (m_have_hi && m_seen) begin
      e.on  = to_ticks(m_hi);
      e.off = to_ticks(m_len);
      e.ovf = ((m_hi / TD >= MAXT) || (m_len / TD >= MAXT)) ? 1 : 0;
      e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    m_seen = en;
    m_len  = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seen    = 0;
    m_have_hi = 0;
    m_len     = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      m_len++;
    end
  endtask

  // Drive a level for n clocks; called at posedge+1.
  task automatic drive_level(input logic v, input int n);
    if (v !== in) model_edge(v);
    in = v;
    step(n);
  endtask

  task automatic en_drop(input int n);
    en        = 1'b0;
    m_seen    = 0;
    m_have_hi = 0;
    step(n);
    en = 1'b1;
  endtask

  task automatic do_reset(input logic lvl);
    reset = 1'b1;
    in    = lvl;
    #1;
    check("rst_on",      on_ticks,  0);
    check("rst_off",     off_ticks, 0);
    check("rst_valid",   valid,     0);
    check("rst_ovf",     overflow,  0);
    check("rst_timeout", timeout,   0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step(6);
  endtask

  // Per-cycle monitor: valid strobe timing, reported values, and holding.
  logic [CWB*2:0] held = '0;
  always @(negedge clk) begin
    bit   ev;
    exp_t e;
    if (reset) begin
      held = '0;
      check("reset_outputs", {on_ticks, off_ticks, overflow, valid, timeout}, 0);
    end else begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      check("valid", valid, ev);
      if (ev) begin
        e = exp_q.pop_front();
        check("on_ticks",  on_ticks,  e.on);
        check("off_ticks", off_ticks, e.off);
        check("overflow",  overflow,  e.ovf);
      end else begin
        check("hold", {on_ticks, off_ticks, overflow}, held);
      end
      held = {on_ticks, off_ticks, overflow};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
    end
  end

  initial begin
    int h, l;
    reset = 1'b1;
    en    = 1'b1;
    in    = 1'b0;
    #2;
    do_reset(1'b0);

    // 30/50 stream from IDLE at in=0.
    repeat (4) begin
      drive_level(1'b1, 30);
      drive_level(1'b0, 50);
    end
    drive_level(1'b1, 30);

    // Non-multiple and short levels.
    drive_level(1'b0, 50);
    drive_level(1'b1, 37);
    drive_level(1'b0, 12);
    drive_level(1'b1, 5);
    drive_level(1'b0, 25);
    drive_level(1'b1, 30);

    // Random periods, including levels below one tick.
    repeat (40) begin
      l = $urandom_range(3, 90);
      h = $urandom_range(3, 90);
      drive_level(1'b0, l);
      drive_level(1'b1, h);
    end

    // en dropped mid-high inside a running 30/50 stream.
    drive_level(1'b0, 50);
    drive_level(1'b1, 15);
    en_drop(10);
    drive_level(1'b1, 20);
    repeat (2) begin
      drive_level(1'b0, 50);
      drive_level(1'b1, 30);
    end

    // Stuck-high level: timeout and saturated report.
    drive_level(1'b0, 50);
    drive_level(1'b1, 2540);
    check("timeout_early", timeout, 0);
    drive_level(1'b1, 20);
    check("timeout_set", timeout, 1);
    drive_level(1'b1, 440);
    check("timeout_held", timeout, 1);
    drive_level(1'b0, 5);
    check("timeout_clear", timeout, 0);
    drive_level(1'b0, 35);
    drive_level(1'b1, 30);
    drive_level(1'b0, 50);
    drive_level(1'b1, 30);

    // Reset mid-low after a report, then the 30/50 stream again.
    drive_level(1'b0, 20);
    do_reset(1'b0);
    repeat (3) begin
      drive_level(1'b1, 30);
      drive_level(1'b0, 50);
    end
    drive_level(1'b1, 30);
    drive_level(1'b0, 20);

    // Start mid-high at reset release.
    do_reset(1'b1);
    drive_level(1'b1, 15);
    drive_level(1'b0, 20);
    drive_level(1'b1, 30);
    drive_level(1'b0, 20);
    drive_level(1'b1, 30);

    step(10);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/square_wave_meter.md
Name: square_wave_meter

Overview:
- Receive-side counterpart to the team's programmable square-wave generator.
- Samples an asynchronous square-wave input and measures the high and low interval lengths of each period in ticks of TICK_DIV clocks (100 ns at 100 MHz with default TICK_DIV=10).
- Reports each completed period as an on/off tick pair with a one-cycle valid strobe.
- Used for loopback checking of generator outputs and for driving the 7-seg display with measured values.

Parameters:
- TICK_DIV, 10, clk cycles per measurement tick; minimum 2.
- CW, 8, width of tick counters and result outputs.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-high; clears all state.
- en  input  1  measurement enable; low forces IDLE.
- in  input  1  asynchronous square-wave input.
- on_ticks  output  CW  high-interval length of the last completed period, in ticks.
- off_ticks  output  CW  low-interval length of the last completed period, in ticks.
- valid  output  1  one-cycle strobe when on_ticks/off_ticks update.
- overflow  output  1  either interval of the reported period saturated; updates with valid.
- timeout  output  1  current-level tick counter at 2^CW-1 (input stuck or too slow).

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk. All flops clear on reset; all outputs reset to 0; state resets to IDLE.
- Input path: 2-FF synchronizer (in_s), plus one delay register (in_d). rise = in_s & ~in_d; fall = ~in_s & in_d. The synchronizer and in_d run regardless of en.
- Level length L = clk cycles between consecutive detected edges. Reported value = min(floor(L/TICK_DIV), 2^CW-1).
- Implementation: a prescaler counting 0..TICK_DIV-1 plus a CW-bit tick counter. The edge cycle counts as clock 1 of the new level. Both counters restart on every detected edge.
- The tick counter saturates at 2^CW-1 and never wraps. Saturation sets the per-level overflow bit. timeout is registered high while the tick counter equals max and clears on the next edge or when en is low.
- FSM:
  - IDLE: counters held at 0. rise -> MEAS_HIGH; fall -> MEAS_LOW. The first partial level is never measured.
  - MEAS_HIGH: on fall, latch tick count into hi_cap and ovf into hi_ovf; set have_hi; go to MEAS_LOW.
  - MEAS_LOW: on rise, if have_hi: on_ticks<=hi_cap, off_ticks<=current count, overflow<=hi_ovf|lo_ovf, valid<=1. Go to MEAS_HIGH.
  - Any state with en=0: go to IDLE next cycle, clear have_hi, counters and timeout. on_ticks/off_ticks/overflow hold last values. valid is 0.
- A period is therefore reported as high-then-low, with one valid per period at the closing rising edge. The first valid requires a full high level followed by a full low level after entering a MEAS state from a rise.
- Latency: valid is high in the cycle after the 3rd clk edge, counting the edge that first samples in=1 as edge 1. The outputs change on that same edge.
- valid is exactly one cycle wide. Outputs are stable between valids.
- Short levels: L < TICK_DIV reports 0. Levels shorter than 2 clocks are not guaranteed to be detected.
- en rising mid-level: starts in IDLE, so the current partial level is discarded.
- reset mid-operation: immediate clear, no valid emitted.

Test Plan:
1. TICK_DIV=10, in high 30 clk / low 50 clk repeating, from IDLE at in=0 -> first rise discarded-start; first valid after the 2nd rise with on_ticks=3, off_ticks=5, overflow=0. Subsequent valid strobes exactly 80 cycles apart, each one cycle wide.
2. Non-multiple levels: high 37 / low 12 -> on_ticks=3, off_ticks=1. High 5 / low 25 -> on_ticks=0, off_ticks=2.
3. CW=8, high held 3000 clk then low 40 then rise -> timeout rises 2550 cycles into the high level and clears at the fall. At the next rise: on_ticks=255, off_ticks=4, overflow=1. The following normal period reports overflow=0.
4. Start mid-high (in=1 at reset release), fall at 15, then low 20 / high 30 / low 20 -> no valid at the first rise. First valid reports on_ticks=3, off_ticks=2.
5. en dropped for 10 cycles mid-high during a running 30/50 stream -> valid stays 0; outputs hold old values. The next valid occurs only after a complete high+low following en reassert, and reports 3/5.
6. Assert reset mid-low, after a valid has been reported -> on_ticks=off_ticks=0, valid=overflow=timeout=0 immediately. After release, behaviour matches scenario 1.
